// File: rtl/mul_add_pkg.sv
// Shared types and default constants for the multiply-add inverse datapath.
package mul_add_pkg;

   localparam int unsigned DefaultWidth  = 8;
   localparam int unsigned DefaultSatVal = 128;

   typedef enum logic [1:0] {IDLE, CALC, DONE} inv_state_e;

   typedef enum logic [1:0] {ERR_OK, ERR_DIV0, ERR_UNDER, ERR_SAT} inv_err_e;

endpackage

// File: rtl/mul_add_inverse_if.sv
// Valid/ready operand and result bundle for mul_add_inverse.
interface mul_add_inverse_if #(
   parameter int unsigned WIDTH = 8
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] in_R;
   logic [WIDTH-1:0] in_B;
   logic [WIDTH-1:0] in_C;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] quot_o;
   logic [WIDTH-1:0] rem_o;
   logic [1:0]       err_o;

   modport slave (
      input  valid_i, in_R, in_B, in_C, ready_i,
      output ready_o, valid_o, quot_o, rem_o, err_o
   );

   modport master (
      output valid_i, in_R, in_B, in_C, ready_i,
      input  ready_o, valid_o, quot_o, rem_o, err_o
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             din,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             qbit
);
   logic [WIDTH:0] shifted;

   always_comb begin
      shifted  = {rem, din};
      qbit     = (shifted >= {1'b0, divisor});
      // When the divisor fits, the true difference is below divisor, so WIDTH bits suffice.
      rem_next = qbit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
   end
endmodule

// File: rtl/mul_add_inverse.sv
// Recovers A = (R - C) / B and the remainder by restoring division, one bit per cycle.
// Optional MUL_ADD_INV_EARLY_EXIT_EN finishes in one edge when the difference is below B.
module mul_add_inverse
   import mul_add_pkg::*;
#(
   parameter int unsigned WIDTH   = DefaultWidth,
   parameter int unsigned SAT_VAL = DefaultSatVal
) (
   input logic              clk,
   input logic              rst,
   mul_add_inverse_if.slave bus
);
   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   inv_state_e       state_q, state_d;
   inv_err_e         err_q, err_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] diff_in;
   logic [WIDTH-1:0] step_rem;
   logic             step_qbit;

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem      (rem_q),
      .din      (diff_q[WIDTH-1]),
      .divisor  (div_q),
      .rem_next (step_rem),
      .qbit     (step_qbit)
   );

   assign diff_in = bus.in_R - bus.in_C;

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      diff_d  = diff_q;
      div_d   = div_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      unique case (state_q)
         IDLE: begin
            if (bus.valid_i) begin
               diff_d  = diff_in;
               div_d   = bus.in_B;
               cnt_d   = '0;
               quot_d  = '0;
               rem_d   = '0;
               valid_d = 1'b0;
               if (bus.in_B == '0) begin
                  err_d   = ERR_DIV0;
                  quot_d  = '1;
                  rem_d   = diff_in;
                  state_d = DONE;
               end else if (bus.in_R < bus.in_C) begin
                  err_d   = ERR_UNDER;
                  state_d = DONE;
               end else begin
                  err_d   = (bus.in_R == WIDTH'(SAT_VAL)) ? ERR_SAT : ERR_OK;
                  state_d = CALC;
`ifdef MUL_ADD_INV_EARLY_EXIT_EN
                  if (diff_in < bus.in_B) begin
                     rem_d   = diff_in;
                     state_d = DONE;
                  end
`endif
               end
            end
         end
         CALC: begin
            diff_d = diff_q << 1;
            rem_d  = step_rem;
            quot_d = {quot_q[WIDTH-2:0], step_qbit};
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // valid_o is registered, so it appears one edge after DONE is entered.
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (bus.ready_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         err_q   <= ERR_OK;
         diff_q  <= '0;
         div_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         diff_q  <= diff_d;
         div_q   <= div_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign bus.ready_o = (state_q == IDLE);
   assign bus.valid_o = valid_q;
   assign bus.quot_o  = quot_q;
   assign bus.rem_o   = rem_q;
   assign bus.err_o   = err_q;
endmodule

// File: tb/tb_mul_add_inverse.sv
// Self-checking bench for mul_add_inverse against an arithmetic reference model.
module tb_mul_add_inverse;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

`ifdef MUL_ADD_INV_EARLY_EXIT_EN
   localparam bit EarlyExit = 1'b1;
`else
   localparam bit EarlyExit = 1'b0;
`endif

   mul_add_inverse_if #(.WIDTH(8)) bus ();

   mul_add_inverse #(
      .WIDTH   (8),
      .SAT_VAL (128)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: expected quotient, remainder, error code and latency from plain arithmetic.
   task automatic model(input int r, input int b, input int c, output int q, output int rm,
                        output int err, output int lat);
      int d;
      if (b == 0) begin
         err = 1; q = 255; rm = (r - c + 256) % 256; lat = 1;
      end else if (r < c) begin
         err = 2; q = 0; rm = 0; lat = 1;
      end else begin
         d   = r - c;
         q   = d / b;
         rm  = d % b;
         err = (r == 128) ? 3 : 0;
         lat = (EarlyExit && d < b) ? 1 : 9;
      end
   endtask

   task automatic run_op(input string name, input int r, input int b, input int c,
                         input int hold);
      int q, rm, err, lat, n;
      bit busy_ok, stable_ok;
      model(r, b, c, q, rm, err, lat);
      @(negedge clk);
      n_checks++;
      if (bus.ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_before: got %b expected 1", name, bus.ready_o);
      end
      bus.valid_i = 1'b1;
      bus.in_R    = 8'(r);
      bus.in_B    = 8'(b);
      bus.in_C    = 8'(c);
      bus.ready_i = 1'b0;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.in_R    = 8'($urandom);
      bus.in_B    = 8'($urandom);
      bus.in_C    = 8'($urandom);
      n       = 0;
      busy_ok = 1'b1;
      while (n < 20) begin
         if (bus.ready_o !== 1'b0) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
         if (bus.valid_o === 1'b1) break;
      end
      n_checks++;
      if (n != lat || bus.valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s latency: got %0d edges (valid=%b) expected %0d", name, n,
                  bus.valid_o, lat);
      end
      n_checks++;
      if (!busy_ok) begin
         n_fail++;
         $display("FAIL %s ready_busy: ready_o was 1 before result, expected 0", name);
      end
      n_checks++;
      if (bus.quot_o !== 8'(q) || bus.rem_o !== 8'(rm) || bus.err_o !== 2'(err)) begin
         n_fail++;
         $display("FAIL %s result: got q=%0d r=%0d e=%0d expected q=%0d r=%0d e=%0d", name,
                  bus.quot_o, bus.rem_o, bus.err_o, q, rm, err);
      end
      stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (bus.valid_o !== 1'b1 || bus.quot_o !== 8'(q) || bus.rem_o !== 8'(rm) ||
             bus.err_o !== 2'(err) || bus.ready_o !== 1'b0) stable_ok = 1'b0;
      end
      if (hold > 0) begin
         n_checks++;
         if (!stable_ok) begin
            n_fail++;
            $display("FAIL %s hold: outputs changed while ready_i low, expected stable", name);
         end
      end
      bus.ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.ready_i = 1'b0;
      n_checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s release: got valid=%b ready=%b expected valid=0 ready=1", name,
                  bus.valid_o, bus.ready_o);
      end
   endtask

   task automatic test_reset();
      rst         = 1'b0;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.in_R    = '0;
      bus.in_B    = '0;
      bus.in_C    = '0;
      #12;
      n_checks++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.quot_o !== 8'd0 ||
          bus.rem_o !== 8'd0 || bus.err_o !== 2'd0) begin
         n_fail++;
         $display("FAIL reset: got rdy=%b vld=%b q=%0d r=%0d e=%0d expected 1 0 0 0 0",
                  bus.ready_o, bus.valid_o, bus.quot_o, bus.rem_o, bus.err_o);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      run_op("basic_59_7_3", 59, 7, 3, 0);
      run_op("hold_100_9_0", 100, 9, 0, 5);
   endtask

   task automatic test_errors();
      run_op("div0", 20, 0, 5, 0);
      run_op("underflow", 4, 3, 9, 0);
      run_op("saturated", 128, 8, 0, 1);
      run_op("div0_beats_under", 3, 0, 9, 0);
      run_op("under_beats_sat", 128, 4, 200, 0);
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.in_R    = 8'd200;
      bus.in_B    = 8'd3;
      bus.in_C    = 8'd0;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.quot_o !== 8'd0 ||
          bus.rem_o !== 8'd0 || bus.err_o !== 2'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got rdy=%b vld=%b q=%0d r=%0d e=%0d expected 1 0 0 0 0",
                  bus.ready_o, bus.valid_o, bus.quot_o, bus.rem_o, bus.err_o);
      end
      @(negedge clk);
      rst = 1'b1;
      run_op("after_reset_200_3", 200, 3, 0, 0);
   endtask

   task automatic test_early_exit();
      run_op("small_5_9_0", 5, 9, 0, 0);
   endtask

   task automatic test_random();
      int r, b, c;
      for (int i = 0; i < 25; i++) begin
         r = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         c = int'($urandom_range(0, 64));
         if ($urandom_range(0, 7) == 0) b = 0;
         if ($urandom_range(0, 7) == 0) r = 128;
         if ($urandom_range(0, 3) == 0) b = int'($urandom_range(1, 12));
         run_op($sformatf("rand%0d", i), r, b, c, int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_basic();
      test_errors();
      test_mid_reset();
      test_early_exit();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mul_add_inverse.md
Name: mul_add_inverse

Overview:
Sequential inverse of the saturating multiply-add datapath. Given a result R, a known operand B and an addend C, it recovers A = (R - C) / B and the remainder, using restoring division at 1 bit per cycle. It sits on the checker/response side of the multiply-add unit to reconstruct operands. Valid/ready handshake on both ends.

Parameters:
WIDTH, 8, data width of R, B, C, quotient and remainder
SAT_VAL, 128, saturation code produced by the forward datapath; flagged as ambiguous

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
valid_i  in  1  input operands valid
ready_o  out  1  block can accept operands
in_R  in  WIDTH  forward result
in_B  in  WIDTH  divisor (known multiplicand)
in_C  in  WIDTH  addend to strip
valid_o  out  1  output valid
ready_i  in  1  downstream accepts output
quot_o  out  WIDTH  recovered operand A
rem_o  out  WIDTH  remainder of (R - C) / B
err_o  out  2  0=OK, 1=div-by-zero, 2=underflow (R<C), 3=saturated input

Behaviour:
- Clock and reset: clk; reset rst, asynchronous, active-low. All state registers reset: state=IDLE, ready_o=1, valid_o=0, quot_o=0, rem_o=0, err_o=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE: ready_o=1. On valid_i&&ready_o, capture diff=in_R-in_C (WIDTH bits), divisor=in_B, count=0, and classify the input:
  - in_B==0 -> err=1, next state DONE.
  - else in_R<in_C -> err=2, next state DONE.
  - else in_R==SAT_VAL -> err=3, next state CALC (result still computed, but flagged).
  - else err=0, next state CALC.
  - Error priority: 1 > 2 > 3.
- CALC: ready_o=0. Each edge performs one restoring step:
  - rem = {rem[WIDTH-2:0], diff[MSB]}; diff shifts left.
  - If rem>=divisor: rem -= divisor and quotient bit=1; else quotient bit=0.
  - count increments. At the edge where count reaches WIDTH-1, the last step completes and next state is DONE.
- Latency: valid_o rises exactly WIDTH+1 edges after the acceptance edge (9 for WIDTH=8), absent the early exit. Error cases 1 and 2 assert valid_o on the first edge after acceptance.
- Error outputs: err=1 gives quot_o=all ones, rem_o=diff. err=2 gives quot_o=0, rem_o=0.
- DONE: valid_o=1; outputs held stable while ready_i=0. On valid_o&&ready_i, next state is IDLE with valid_o=0. There is no same-cycle re-accept, so ready_o rises in the cycle after the handshake.
- Operands are registered at acceptance; in_* changes during CALC or DONE have no effect.
- valid_i while ready_o=0 is ignored; the source must hold it.
- Asynchronous reset mid-CALC or mid-DONE aborts the operation immediately and discards the result.
- Arithmetic: all unsigned, no intermediate overflow. rem needs WIDTH+1 bits internally for the compare/subtract.

Optional Feature:
MUL_ADD_INV_EARLY_EXIT_EN
- Defined: in IDLE, if no error and diff<in_B, go straight to DONE with quot_o=0, rem_o=diff. Latency 1 edge.
- Undefined: every non-error operation takes the full WIDTH+1 edges.

Decomposition:
- Package mul_add_pkg holds:
  - default WIDTH and SAT_VAL constants;
  - enum inv_state_e {IDLE, CALC, DONE};
  - enum inv_err_e {ERR_OK, ERR_DIV0, ERR_UNDER, ERR_SAT} (2 bits).
- One combinational sub-module, div_step: inputs rem, next dividend bit, divisor; outputs new rem and quotient bit. Instantiated once in the CALC path.

Test Plan:
- R=59, B=7, C=3 -> after 9 edges valid_o=1, quot_o=8, rem_o=0, err_o=0; ready_o=0 throughout CALC.
- R=100, B=9, C=0 with ready_i held low 5 cycles -> quot_o=11, rem_o=1 held stable for 5 cycles; IDLE one cycle after ready_i=1.
- R=20, B=0, C=5 -> valid_o after 1 edge, err_o=1, quot_o=255, rem_o=15. Then R=4, B=3, C=9 -> err_o=2, quot_o=0.
- R=128, B=8, C=0 -> quot_o=16, rem_o=0, err_o=3.
- Assert rst low at count=4 of R=200, B=3, C=0 -> all outputs 0, ready_o=1. A new R=200 request after reset -> quot_o=66, rem_o=2.
- Early exit: R=5, B=9, C=0 -> with MUL_ADD_INV_EARLY_EXIT_EN, valid_o after 1 edge; without it, after 9 edges. Both give quot_o=0, rem_o=5.
